alu_exec_unit: RTL and testbench

Parametrised, handshaked ALU control-and-execute stage for the RISC-V datapath. It decodes Opcode/funct3/funct7 into a widened 4-bit ALU_Cnt and executes the operation on XLEN-bit operands. It also flags illegal encodings and resolves branch conditions. Shifts can run iteratively, one bit per cycle, to save area. It sits between the register-read stage and writeback/branch logic, with valid/ready on both sides.

---
 rtl/alu_exec_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked RISC-V ALU decode/execute stage: decodes Opcode/funct3/funct7 into ALU_Cnt,
// executes on XLEN-bit operands, flags illegal encodings and resolves branch conditions.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter bit SHIFT_ITER = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      Opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      ALU_Cnt,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            br_taken,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_ILL   = 4'd15;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        alu_cnt_q, alu_cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              br_taken_q, br_taken_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [SHW-1:0]    count_q, count_d;

    logic [3:0]        op_c;
    logic [SHW-1:0]    shamt_c;
    logic              is_shift_c;
    logic [XLEN-1:0]   res_c;

    function automatic logic [3:0] decode(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7);
        logic [3:0] base;
        case (f3)
            3'd0:    base = OP_ADD;
            3'd1:    base = OP_SLL;
            3'd2:    base = OP_SLT;
            3'd3:    base = OP_SLTU;
            3'd4:    base = OP_XOR;
            3'd5:    base = OP_SRL;
            3'd6:    base = OP_OR;
            default: base = OP_AND;
        endcase
        decode = OP_ILL;
        case (opc)
            7'd51: begin
                if (f3 == 3'd0 || f3 == 3'd5) begin
                    if (f7 == 7'd0)       decode = base;
                    else if (f7 == 7'd32) decode = (f3 == 3'd0) ? OP_SUB : OP_SRA;
                end else if (f7 == 7'd0) begin
                    decode = base;
                end
            end
            7'd19: begin
                // Immediate forms ignore funct7 except where it encodes the shift kind.
                if (f3 == 3'd1) begin
                    if (f7 == 7'd0) decode = OP_SLL;
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'd0)       decode = OP_SRL;
                    else if (f7 == 7'd32) decode = OP_SRA;
                end else begin
                    decode = base;
                end
            end
            7'd3, 7'd35: decode = OP_ADD;
            7'd55:       decode = OP_PASSB;
            7'd99:       if (f3 != 3'd2 && f3 != 3'd3) decode = OP_SUB;
            default:     decode = OP_ILL;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] execute(input logic [3:0] cnt, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] as_;
        logic signed [XLEN-1:0] bs_;
        logic [SHW-1:0]         sh;
        as_     = a;
        bs_     = b;
        sh      = b[SHW-1:0];
        execute = '0;
        case (cnt)
            OP_ADD:   execute = a + b;
            OP_SUB:   execute = a - b;
            OP_SLL:   execute = a << sh;
            OP_SLT:   execute[0] = (as_ < bs_);
            OP_SLTU:  execute[0] = (a < b);
            OP_XOR:   execute = a ^ b;
            OP_SRL:   execute = a >> sh;
            OP_SRA:   execute = as_ >>> sh;
            OP_OR:    execute = a | b;
            OP_AND:   execute = a & b;
            OP_PASSB: execute = b;
            default:  execute = '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] shift1(input logic [3:0] cnt, input logic [XLEN-1:0] v);
        case (cnt)
            OP_SLL:  shift1 = {v[XLEN-2:0], 1'b0};
            OP_SRL:  shift1 = {1'b0, v[XLEN-1:1]};
            default: shift1 = {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    function automatic logic branch(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] as_;
        logic signed [XLEN-1:0] bs_;
        as_ = a;
        bs_ = b;
        case (f3)
            3'd0:    branch = (a == b);
            3'd1:    branch = (a != b);
            3'd4:    branch = (as_ < bs_);
            3'd5:    branch = (as_ >= bs_);
            3'd6:    branch = (a < b);
            3'd7:    branch = (a >= b);
            default: branch = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_cnt_d   = alu_cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        br_taken_d  = br_taken_q;
        illegal_d   = illegal_q;
        acc_d       = acc_q;
        count_d     = count_q;
        op_c        = decode(Opcode, funct3, funct7);
        shamt_c     = B[SHW-1:0];
        is_shift_c  = (op_c == OP_SLL) || (op_c == OP_SRL) || (op_c == OP_SRA);
        res_c       = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_cnt_d  = op_c;
                    illegal_d  = (op_c == OP_ILL);
                    br_taken_d = (Opcode == 7'd99) && (op_c != OP_ILL) && branch(funct3, A, B);
                    if (SHIFT_ITER && is_shift_c && shamt_c != '0) begin
                        // First bit is shifted on the accepting edge so latency equals shamt.
                        acc_d   = shift1(op_c, A);
                        count_d = shamt_c - SHW'(1);
                        if (shamt_c == SHW'(1)) begin
                            result_d    = acc_d;
                            zero_d      = (acc_d == '0);
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        res_c       = (SHIFT_ITER && is_shift_c) ? A : execute(op_c, A, B);
                        result_d    = res_c;
                        zero_d      = (res_c == '0);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d   = shift1(alu_cnt_q, acc_q);
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    result_d    = acc_d;
                    zero_d      = (acc_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_cnt_q   <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            br_taken_q  <= 1'b0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_cnt_q   <= alu_cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            br_taken_q  <= br_taken_d;
            illegal_q   <= illegal_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign ALU_Cnt   = alu_cnt_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign br_taken  = br_taken_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32, iterative shifter).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  Opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ALU_Cnt;
    logic [31:0] result;
    logic        zero;
    logic        br_taken;
    logic        illegal;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHIFT_ITER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Opcode(Opcode), .funct3(funct3), .funct7(funct7), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_Cnt(ALU_Cnt), .result(result),
        .zero(zero), .br_taken(br_taken), .illegal(illegal)
    );

    // Present one request for exactly one edge, then scramble the inputs.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Opcode = op; funct3 = f3; funct7 = f7; A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = ~a; B = ~b; Opcode = 7'd51; funct3 = ~f3; funct7 = 7'd32;
    endtask

    task automatic wait_out(output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 64) begin
            rdy_seen |= in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        rdy_seen |= in_ready;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({in_ready, out_valid, result, ALU_Cnt, zero, br_taken, illegal} !== 41'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b res=%h cnt=%0d z=%b br=%b ill=%b, want all 0",
                     in_ready, out_valid, result, ALU_Cnt, zero, br_taken, illegal);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_alu_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input logic [3:0] exp_cnt,
                               input logic exp_ill, input logic exp_br, input int exp_lat);
        int lat;
        bit seen;
        issue(op, f3, f7, a, b);
        wait_out(lat, seen);
        nvec++;
        if ({out_valid, result, ALU_Cnt, zero, br_taken, illegal} !==
            {1'b1, exp_res, exp_cnt, (exp_res == 32'd0), exp_br, exp_ill}) begin
            nerr++;
            $display("FAIL %s: got ov=%b res=%h cnt=%0d z=%b br=%b ill=%b, want ov=1 res=%h cnt=%0d z=%b br=%b ill=%b",
                     name, out_valid, result, ALU_Cnt, zero, br_taken, illegal,
                     exp_res, exp_cnt, (exp_res == 32'd0), exp_br, exp_ill);
        end
        nvec++;
        if (lat != exp_lat || seen) begin
            nerr++;
            $display("FAIL %s_latency: got lat=%0d ready_seen=%b, want lat=%0d ready_seen=0",
                     name, lat, seen, exp_lat);
        end
        drain();
    endtask

    // Leaves the SRA result waiting in DONE for the backpressure test.
    task automatic test_iter_shift();
        int lat;
        bit seen;
        issue(7'd51, 3'd5, 7'd32, 32'h8000_0000, 32'h0000_0024);
        wait_out(lat, seen);
        nvec++;
        if (lat != 4 || seen) begin
            nerr++;
            $display("FAIL sra_iter_latency: got lat=%0d ready_seen=%b, want lat=4 ready_seen=0", lat, seen);
        end
        nvec++;
        if ({out_valid, result, ALU_Cnt, zero, illegal} !== {1'b1, 32'hF800_0000, 4'd7, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL sra_iter_result: got ov=%b res=%h cnt=%0d z=%b ill=%b, want ov=1 res=f8000000 cnt=7 z=0 ill=0",
                     out_valid, result, ALU_Cnt, zero, illegal);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; Opcode = 7'd51; funct3 = 3'd0; funct7 = 7'd0;
            A = 32'h1111_1111 * (i + 1); B = 32'h2;
            @(posedge clk);
            #1;
            nvec++;
            if ({out_valid, in_ready, result, ALU_Cnt} !== {1'b1, 1'b0, 32'hF800_0000, 4'd7}) begin
                nerr++;
                $display("FAIL backpressure_hold%0d: got ov=%b rdy=%b res=%h cnt=%0d, want ov=1 rdy=0 res=f8000000 cnt=7",
                         i, out_valid, in_ready, result, ALU_Cnt);
            end
        end
        in_valid = 1'b0;
        drain();
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL backpressure_release: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        issue(7'd51, 3'd1, 7'd0, 32'h0000_0001, 32'd31);
        repeat (5) @(posedge clk);
        #1;
        nvec++;
        if ({out_valid, in_ready} !== 2'b00) begin
            nerr++;
            $display("FAIL sll31_in_shift: got ov=%b rdy=%b, want ov=0 rdy=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({out_valid, in_ready, ALU_Cnt, result} !== 38'd0) begin
            nerr++;
            $display("FAIL reset_mid_shift: got ov=%b rdy=%b cnt=%0d res=%h, want all 0",
                     out_valid, in_ready, ALU_Cnt, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL after_reset_idle: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
        test_alu_op("add_after_reset", 7'd51, 3'd0, 7'd0, 32'd2, 32'd3, 32'd5, 4'd0, 1'b0, 1'b0, 1);
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; Opcode = '0; funct3 = '0; funct7 = '0; A = '0; B = '0;
        test_reset();
        test_alu_op("sub",       7'd51, 3'd0, 7'd32,  32'd5,        32'd7,        32'hFFFF_FFFE, 4'd1,  1'b0, 1'b0, 1);
        test_alu_op("addi_f7",   7'd19, 3'd0, 7'd126, 32'd10,       32'hFFFF_FFFF, 32'd9,        4'd0,  1'b0, 1'b0, 1);
        test_alu_op("slli_bad",  7'd19, 3'd1, 7'd1,   32'd1,        32'd2,        32'd0,         4'd15, 1'b1, 1'b0, 1);
        test_alu_op("add_bad",   7'd51, 3'd0, 7'd1,   32'd1,        32'd2,        32'd0,         4'd15, 1'b1, 1'b0, 1);
        test_alu_op("srai_bad",  7'd19, 3'd5, 7'd1,   32'd8,        32'd2,        32'd0,         4'd15, 1'b1, 1'b0, 1);
        test_alu_op("bad_opc",   7'h7F, 3'd0, 7'd0,   32'd1,        32'd1,        32'd0,         4'd15, 1'b1, 1'b0, 1);
        test_alu_op("bne_eq",    7'd99, 3'd1, 7'h33,  32'd3,        32'd3,        32'd0,         4'd1,  1'b0, 1'b0, 1);
        test_alu_op("bne_ne",    7'd99, 3'd1, 7'h33,  32'd3,        32'd4,        32'hFFFF_FFFF, 4'd1,  1'b0, 1'b1, 1);
        test_alu_op("blt",       7'd99, 3'd4, 7'd0,   32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFE, 4'd1,  1'b0, 1'b1, 1);
        test_alu_op("bge",       7'd99, 3'd5, 7'd0,   32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFE, 4'd1,  1'b0, 1'b0, 1);
        test_alu_op("bltu",      7'd99, 3'd6, 7'd0,   32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFE, 4'd1,  1'b0, 1'b0, 1);
        test_alu_op("bgeu",      7'd99, 3'd7, 7'd0,   32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFE, 4'd1,  1'b0, 1'b1, 1);
        test_alu_op("br_f3_2",   7'd99, 3'd2, 7'd0,   32'd5,        32'd5,        32'd0,         4'd15, 1'b1, 1'b0, 1);
        test_alu_op("xor",       7'd51, 3'd4, 7'd0,   32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 4'd5, 1'b0, 1'b0, 1);
        test_alu_op("slt",       7'd51, 3'd2, 7'd0,   32'd1,        32'hFFFF_FFFF, 32'd0,         4'd3,  1'b0, 1'b0, 1);
        test_alu_op("sltu",      7'd51, 3'd3, 7'd0,   32'd1,        32'hFFFF_FFFF, 32'd1,         4'd4,  1'b0, 1'b0, 1);
        test_alu_op("ori",       7'd19, 3'd6, 7'h55,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'd8, 1'b0, 1'b0, 1);
        test_alu_op("andi",      7'd19, 3'd7, 7'd0,   32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 4'd9, 1'b0, 1'b0, 1);
        test_alu_op("lui",       7'd55, 3'd0, 7'd0,   32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000, 4'd10, 1'b0, 1'b0, 1);
        test_alu_op("load",      7'd3,  3'd2, 7'd0,   32'h0000_0100, 32'd4,       32'h0000_0104, 4'd0,  1'b0, 1'b0, 1);
        test_alu_op("store",     7'd35, 3'd2, 7'd0,   32'd8,        32'hFFFF_FFFC, 32'd4,         4'd0,  1'b0, 1'b0, 1);
        test_alu_op("sll_sh0",   7'd51, 3'd1, 7'd0,   32'd5,        32'h0000_0020, 32'd5,         4'd2,  1'b0, 1'b0, 1);
        test_alu_op("srli_sh1",  7'd19, 3'd5, 7'd0,   32'h8000_0000, 32'd1,       32'h4000_0000, 4'd6,  1'b0, 1'b0, 1);
        test_alu_op("srl_sh3",   7'd51, 3'd5, 7'd0,   32'h0000_00F0, 32'd3,       32'h0000_001E, 4'd6,  1'b0, 1'b0, 3);
        test_alu_op("slli_sh8",  7'd19, 3'd1, 7'd0,   32'h0000_0012, 32'd8,       32'h0000_1200, 4'd2,  1'b0, 1'b0, 8);
        test_iter_shift();
        test_backpressure();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
